// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall/clear
// generation, EX operand forwarding selects and a multi-cycle-unit hold FSM.
module pipeline_hazard_ctrl #(
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RF_AW-1:0] id_rs1,
   input  logic [RF_AW-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RF_AW-1:0] id_rd,
   input  logic             id_we,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   input  logic             mc_start,
   input  logic             mc_done,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_clear,
   output logic             idex_stall,
   output logic             idex_clear,
   output logic             exmem_clear,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [31:0]      stall_count
);

   typedef enum logic {
      RUN,
      MC_BUSY
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [RF_AW-1:0] rd;
      logic             we;
      logic             is_load;
   } stage_t;

   typedef struct packed {
      stage_t           info;
      logic [RF_AW-1:0] rs1;
      logic [RF_AW-1:0] rs2;
      logic             use_rs1;
      logic             use_rs2;
   } ex_stage_t;

   state_t      state_q, state_d;
   ex_stage_t   ex_q, ex_d;
   stage_t      mem_q, mem_d;
   stage_t      wb_q, wb_d;
   logic [31:0] stall_count_q, stall_count_d;
   logic        mc_hold;
   logic        load_use;

   // x0 is never a live destination, so bubbles (all-zero entries) cannot match
   function automatic logic live(input stage_t s);
      return s.valid && s.we && (s.rd != '0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [RF_AW-1:0] rs, input logic use_rs,
                                          input stage_t mem, input stage_t wb);
      logic [1:0] sel;
      sel = 2'b00;
      if (live(mem) && !mem.is_load && (mem.rd == rs) && use_rs) begin
         sel = 2'b01;
      end else if (live(wb) && (wb.rd == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_clear  = 1'b0;
      idex_stall  = 1'b0;
      idex_clear  = 1'b0;
      exmem_clear = 1'b0;
      state_d     = state_q;
      mc_hold     = (state_q == MC_BUSY) ? !mc_done : (mc_start && !mc_done);
      load_use    = live(ex_q.info) && ex_q.info.is_load &&
                    (((ex_q.info.rd == id_rs1) && id_use_rs1) ||
                     ((ex_q.info.rd == id_rs2) && id_use_rs2));

      // Multi-cycle hold outranks redirect, which outranks the load-use bubble
      if (rst_n) begin
         if (mc_hold) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_clear = 1'b1;
         end else if (ex_redirect) begin
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
         end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_clear = 1'b1;
         end
      end

      case (state_q)
         RUN:     if (mc_start && !mc_done) state_d = MC_BUSY;
         MC_BUSY: if (mc_done) state_d = RUN;
         default: state_d = RUN;
      endcase

      ex_d = ex_q;
      if (!idex_stall) begin
         if (idex_clear) begin
            ex_d = '0;
         end else begin
            ex_d.info.valid   = 1'b1;
            ex_d.info.rd      = id_rd;
            ex_d.info.we      = id_we;
            ex_d.info.is_load = id_is_load;
            ex_d.rs1          = id_rs1;
            ex_d.rs2          = id_rs2;
            ex_d.use_rs1      = id_use_rs1;
            ex_d.use_rs2      = id_use_rs2;
         end
      end

      mem_d = exmem_clear ? '0 : ex_q.info;
      wb_d  = mem_q;

      stall_count_d = stall_count_q;
      if (pc_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end

      fwd_a = fwd_sel(ex_q.rs1, ex_q.use_rs1, mem_q, wb_q);
      fwd_b = fwd_sel(ex_q.rs2, ex_q.use_rs2, mem_q, wb_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         ex_q          <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ex_q          <= ex_d;
         mem_q         <= mem_d;
         wb_q          <= wb_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed test-plan scenarios plus
// random traffic, scored against an instruction-level pipeline model.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
   logic        ex_redirect = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
   logic        pc_stall, ifid_stall, ifid_clear, idex_stall, idex_clear, exmem_clear;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] stall_count;

   int assertions = 0;
   int failures = 0;

   typedef struct {
      bit valid;
      int rd;
      bit we;
      bit ld;
      int rs1;
      int rs2;
      bit u1;
      bit u2;
   } instr_t;

   typedef struct {
      bit     pcS, ifS, ifC, idS, idC, exC;
      int     fa, fb;
      longint cnt;
   } exp_t;

   instr_t mEx, mMem, mWb;
   bit     mBusy;
   longint mCount;
   exp_t   expQ[$];
   exp_t   curExp;
   exp_t   monExp;
   longint base;

   pipeline_hazard_ctrl #(.RF_AW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
      .ex_redirect(ex_redirect), .mc_start(mc_start), .mc_done(mc_done),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_clear(ifid_clear),
      .idex_stall(idex_stall), .idex_clear(idex_clear), .exmem_clear(exmem_clear),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Shared comparison: every check in the bench goes through here
   task automatic checkOutput(input string name, input longint act, input longint req);
      assertions++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic instr_t bubble();
      instr_t b;
      b.valid = 0; b.rd = 0; b.we = 0; b.ld = 0;
      b.rs1 = 0; b.rs2 = 0; b.u1 = 0; b.u2 = 0;
      return b;
   endfunction

   function automatic bit isLive(input instr_t i);
      return i.valid && i.we && (i.rd != 0);
   endfunction

   // Youngest non-load producer wins; a WB writer is the fallback
   function automatic int fwdModel(input int rs, input bit useRs);
      if (isLive(mMem) && !mMem.ld && (mMem.rd == rs) && useRs) return 1;
      if (isLive(mWb) && (mWb.rd == rs)) return 2;
      return 0;
   endfunction

   task automatic modelReset();
      mEx = bubble(); mMem = bubble(); mWb = bubble();
      mBusy = 0; mCount = 0;
   endtask

   // Drive one ID-stage instruction plus EX-side events, predict this cycle's outputs
   task automatic applyStimulus(input int rs1, input int rs2, input bit u1, input bit u2,
                                input int rd, input bit we, input bit ld,
                                input bit redir, input bit start, input bit done);
      exp_t   e;
      instr_t n;
      bit     held, lu;
      @(posedge clk);
      #1;
      id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = 5'(rd); id_we = we; id_is_load = ld;
      ex_redirect = redir; mc_start = start; mc_done = done;
      e.pcS = 0; e.ifS = 0; e.ifC = 0; e.idS = 0; e.idC = 0; e.exC = 0;
      e.fa = 0; e.fb = 0; e.cnt = mCount;
      if (!rst_n) begin
         expQ.push_back(e);
         curExp = e;
         return;
      end
      held = mBusy ? !done : (start && !done);
      lu = isLive(mEx) && mEx.ld && ((mEx.rd == rs1 && u1) || (mEx.rd == rs2 && u2));
      if (held) begin
         e.pcS = 1; e.ifS = 1; e.idS = 1; e.exC = 1;
      end else if (redir) begin
         e.ifC = 1; e.idC = 1;
      end else if (lu) begin
         e.pcS = 1; e.ifS = 1; e.idC = 1;
      end
      e.fa = fwdModel(mEx.rs1, mEx.u1);
      e.fb = fwdModel(mEx.rs2, mEx.u2);
      if (mEx.valid && isLive(mMem) && mMem.ld &&
          ((mMem.rd == mEx.rs1 && mEx.u1) || (mMem.rd == mEx.rs2 && mEx.u2))) begin
         failures++;
         $display("[TB] FAIL memLoadHazard actual=1 required=0 at %0t", $time);
      end
      expQ.push_back(e);
      curExp = e;
      n.valid = 1; n.rd = rd; n.we = we; n.ld = ld;
      n.rs1 = rs1; n.rs2 = rs2; n.u1 = u1; n.u2 = u2;
      mWb  = mMem;
      mMem = e.exC ? bubble() : mEx;
      if (!e.idS) mEx = e.idC ? bubble() : n;
      mBusy = held;
      if (e.pcS && mCount < 64'hFFFF_FFFF) mCount++;
   endtask

   task automatic nop();
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a full output set, compared on the falling edge
   always @(negedge clk) begin
      if (expQ.size() != 0) begin
         monExp = expQ.pop_front();
         checkOutput("pc_stall", longint'(pc_stall), longint'(monExp.pcS));
         checkOutput("ifid_stall", longint'(ifid_stall), longint'(monExp.ifS));
         checkOutput("ifid_clear", longint'(ifid_clear), longint'(monExp.ifC));
         checkOutput("idex_stall", longint'(idex_stall), longint'(monExp.idS));
         checkOutput("idex_clear", longint'(idex_clear), longint'(monExp.idC));
         checkOutput("exmem_clear", longint'(exmem_clear), longint'(monExp.exC));
         checkOutput("fwd_a", longint'(fwd_a), longint'(monExp.fa));
         checkOutput("fwd_b", longint'(fwd_b), longint'(monExp.fb));
         checkOutput("stall_count", longint'(stall_count), monExp.cnt);
      end
   end

   initial begin
      modelReset();
      // Reset: inputs that would otherwise stall or clear must be masked
      applyStimulus(5, 5, 1, 1, 5, 1, 1, 1, 1, 0);
      #1;
      checkOutput("rstPcStall", longint'(pc_stall), 0);
      checkOutput("rstIfidClear", longint'(ifid_clear), 0);
      checkOutput("rstCount", longint'(stall_count), 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // x0 immunity: NOPs then a reader of x0
      nop(); nop(); nop();
      applyStimulus(0, 0, 1, 0, 8, 1, 0, 0, 0, 0);
      #1 checkOutput("x0NoStall", longint'(pc_stall), 0);
      nop();
      #1 checkOutput("x0FwdA", longint'(fwd_a), 0);

      // Load-use: LW x5, then ADD x6,x5,x0 (held in ID for the bubble)
      applyStimulus(1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
      applyStimulus(5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
      #1;
      base = curExp.cnt;
      checkOutput("luPcStall", longint'(pc_stall), 1);
      checkOutput("luIfidStall", longint'(ifid_stall), 1);
      checkOutput("luIdexClear", longint'(idex_clear), 1);
      applyStimulus(5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
      #1;
      checkOutput("luRelease", longint'(pc_stall), 0);
      checkOutput("luCount", longint'(stall_count), base + 1);
      nop();
      #1 checkOutput("luFwdA", longint'(fwd_a), 2);

      // Forward priority: two x7 writers, then a rs2 reader
      applyStimulus(1, 2, 1, 1, 7, 1, 0, 0, 0, 0);
      applyStimulus(3, 4, 1, 1, 7, 1, 0, 0, 0, 0);
      applyStimulus(0, 7, 0, 1, 8, 1, 0, 0, 0, 0);
      nop();
      #1 checkOutput("fwdBMem", longint'(fwd_b), 1);
      applyStimulus(1, 2, 1, 1, 7, 1, 0, 0, 0, 0);
      nop();
      applyStimulus(0, 7, 0, 1, 8, 1, 0, 0, 0, 0);
      nop();
      #1 checkOutput("fwdBWb", longint'(fwd_b), 2);

      // Redirect overrides a pending load-use
      applyStimulus(1, 0, 1, 0, 5, 1, 1, 0, 0, 0);
      applyStimulus(5, 0, 1, 0, 6, 1, 0, 1, 0, 0);
      #1;
      base = curExp.cnt;
      checkOutput("rdIfidClear", longint'(ifid_clear), 1);
      checkOutput("rdIdexClear", longint'(idex_clear), 1);
      checkOutput("rdPcStall", longint'(pc_stall), 0);
      nop();
      #1 checkOutput("rdCount", longint'(stall_count), base);

      // Multi-cycle: DIV x9 enters EX, done arrives 4 cycles after start
      applyStimulus(1, 2, 1, 1, 9, 1, 0, 0, 0, 0);
      applyStimulus(9, 0, 1, 0, 10, 1, 0, 0, 1, 0);
      #1;
      base = curExp.cnt;
      checkOutput("mcStall0", longint'(pc_stall), 1);
      checkOutput("mcExmem0", longint'(exmem_clear), 1);
      applyStimulus(9, 0, 1, 0, 10, 1, 0, 0, 0, 0);
      applyStimulus(9, 0, 1, 0, 10, 1, 0, 1, 0, 0);
      #1;
      checkOutput("mcRedirIgnored", longint'(ifid_clear), 0);
      checkOutput("mcStall2", longint'(pc_stall), 1);
      applyStimulus(9, 0, 1, 0, 10, 1, 0, 0, 0, 0);
      applyStimulus(9, 0, 1, 0, 10, 1, 0, 0, 0, 1);
      #1;
      checkOutput("mcDoneStall", longint'(pc_stall), 0);
      checkOutput("mcDoneExmem", longint'(exmem_clear), 0);
      checkOutput("mcCount", longint'(stall_count), base + 4);
      nop();

      // Async reset in the middle of a multi-cycle hold, off the clock edge
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("arPcStall", longint'(pc_stall), 0);
      checkOutput("arExmem", longint'(exmem_clear), 0);
      checkOutput("arIdexStall", longint'(idex_stall), 0);
      checkOutput("arCount", longint'(stall_count), 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mc_start = 1'b0;
      nop();
      #1 checkOutput("arNoStall", longint'(pc_stall), 0);
      nop();

      // Random traffic over a small register window to force frequent matches
      for (int i = 0; i < 800; i++) begin
         int  r1, r2, rd;
         bit  u1, u2, we, ld, redir, start, done;
         r1 = $urandom_range(0, 7);
         r2 = $urandom_range(0, 7);
         rd = $urandom_range(0, 7);
         u1 = $urandom_range(0, 3) != 0;
         u2 = $urandom_range(0, 1) != 0;
         we = $urandom_range(0, 3) != 0;
         ld = $urandom_range(0, 3) == 0;
         redir = $urandom_range(0, 9) == 0;
         start = !mBusy && ($urandom_range(0, 7) == 0);
         done = $urandom_range(0, 3) == 0;
         applyStimulus(r1, r2, u1, u2, rd, we, ld, redir, start, done);
      end

      for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain actual=%0d required=0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
